// File: rtl/lm70_pkg.sv
// Shared types and constants for the LM70-style sensor model.
// Includes a helper that turns whole degrees C into a TEMP_SET word.
package lm70_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } lm70_state_e;

    localparam logic [15:0] DEVICE_ID = 16'h8100;
    localparam logic [4:0]  LSB_FILL  = 5'b11111;
    localparam logic [7:0]  SHDN_CODE = 8'hFF;
    localparam logic [7:0]  RUN_CODE  = 8'h00;

    // 0.25 C per LSB, so whole degrees land at bit 2 of the 11-bit field
    function automatic logic [15:0] temp_word(input int deg_c);
        logic [10:0] q;
        q = 11'(deg_c * 4);
        return {q, 5'b00000};
    endfunction

endpackage

// File: rtl/lm70_shift_frame.sv
// Bit counter plus read (out) and write (cmd) shift registers for one frame.
// Latency: registers update on the SCK rising edge; cmd_next is combinational.
// Backpressure: none; the owning FSM decides every load/shift/clear.
module lm70_shift_frame (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cnt_clr,
    input  logic        cnt_inc,
    input  logic        load,
    input  logic [15:0] load_dat,
    input  logic        shift_rd,
    input  logic        shift_wr,
    input  logic        sio_in,
    output logic        out_msb,
    output logic        last_bit,
    output logic [15:0] cmd_next
);

    logic [3:0]  cnt;
    logic [15:0] out_shreg;
    logic [15:0] cmd_shreg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            out_shreg <= 16'd0;
            cmd_shreg <= 16'd0;
        end else begin
            if (cnt_clr)
                cnt <= 4'd0;
            else if (cnt_inc)
                cnt <= cnt + 4'd1;

            if (load)
                out_shreg <= load_dat;
            else if (shift_rd)
                out_shreg <= {out_shreg[14:0], 1'b0};

            if (shift_wr)
                cmd_shreg <= cmd_next;
        end
    end

    // The command is judged including the bit being sampled this edge
    assign cmd_next = {cmd_shreg[14:0], sio_in};
    assign out_msb  = out_shreg[15];
    assign last_bit = (cnt == 4'hF);

endmodule

// File: rtl/lm70_sensor_model.sv
// LM70-style sensor: 16-bit read of temperature/ID, then 16-bit command write.
// Latency: bit 15 drives from the CS-low load edge; SIO releases combinationally on CS high.
// Backpressure: none; the host owns SCK and CS, and CS high aborts any frame.
module lm70_sensor_model #(
    parameter logic [15:0] DEVICE_ID = lm70_pkg::DEVICE_ID,
    parameter logic [4:0]  LSB_FILL  = lm70_pkg::LSB_FILL,
    parameter logic [7:0]  SHDN_CODE = lm70_pkg::SHDN_CODE,
    parameter logic [7:0]  RUN_CODE  = lm70_pkg::RUN_CODE
) (
    input  logic        SCK,
    input  logic        RSTN,
    input  logic        CS,
    input  logic [15:0] TEMP_SET,
    inout  wire         SIO
);
    import lm70_pkg::*;

    lm70_state_e state, state_nxt;
    logic        shutdown, shutdown_nxt;
    logic        cnt_clr, cnt_inc, load, shift_rd, shift_wr;
    logic        out_msb, last_bit;
    logic [15:0] cmd_next;
    logic [15:0] load_dat;
    logic        unused_temp_lsbs;

    assign unused_temp_lsbs = ^TEMP_SET[4:0];
    assign load_dat = shutdown ? DEVICE_ID : {TEMP_SET[15:5], LSB_FILL};

    always_ff @(posedge SCK) begin
        if (!RSTN) begin
            state    <= ST_IDLE;
            shutdown <= 1'b0;
        end else begin
            state    <= state_nxt;
            shutdown <= shutdown_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        shutdown_nxt = shutdown;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        load         = 1'b0;
        shift_rd     = 1'b0;
        shift_wr     = 1'b0;
        if (CS) begin
            state_nxt = ST_IDLE;
            cnt_clr   = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    load      = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = ST_READ;
                end
                ST_READ: begin
                    shift_rd = 1'b1;
                    if (last_bit) begin
                        cnt_clr   = 1'b1;
                        state_nxt = ST_WRITE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                ST_WRITE: begin
                    shift_wr = 1'b1;
                    if (last_bit) begin
                        cnt_clr   = 1'b1;
                        state_nxt = ST_DONE;
                        if (cmd_next[7:0] == SHDN_CODE)
                            shutdown_nxt = 1'b1;
                        else if (cmd_next[7:0] == RUN_CODE)
                            shutdown_nxt = 1'b0;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                ST_DONE: state_nxt = ST_DONE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    lm70_shift_frame u_frame (
        .clk      (SCK),
        .rst_n    (RSTN),
        .cnt_clr  (cnt_clr),
        .cnt_inc  (cnt_inc),
        .load     (load),
        .load_dat (load_dat),
        .shift_rd (shift_rd),
        .shift_wr (shift_wr),
        .sio_in   (SIO),
        .out_msb  (out_msb),
        .last_bit (last_bit),
        .cmd_next (cmd_next)
    );

    assign SIO = (state == ST_READ && !CS && RSTN) ? out_msb : 1'bz;

endmodule

// File: tb/tb_lm70_sensor_model.sv
// Host-side bench for lm70_sensor_model: drives frames, scoreboards read words.
// An idle SIO reads back as 1 through the pullup.
module tb_lm70_sensor_model;
    import lm70_pkg::*;

    logic        sck = 1'b0;
    logic        rstn;
    logic        cs;
    logic [15:0] temp_set;
    logic        host_en;
    logic        host_val;
    wire         sio;

    int n_vec  = 0;
    int n_miss = 0;
    logic [15:0] exp_q[$];

    assign sio = host_en ? host_val : 1'bz;
    pullup (sio);

    always #5 sck = ~sck;

    lm70_sensor_model dut (
        .SCK      (sck),
        .RSTN     (rstn),
        .CS       (cs),
        .TEMP_SET (temp_set),
        .SIO      (sio)
    );

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts and ends on a falling edge. rd_bits < 16 aborts the read early;
    // rst_wr pulses RSTN part-way through the command write.
    task automatic run_frame(input logic [15:0] wr, input int rd_bits, input bit rst_wr);
        logic [15:0] rd;
        logic [15:0] exp;
        logic [15:0] mask;
        logic [15:0] t_save;
        rd     = 16'h0000;
        exp    = exp_q.pop_front();
        t_save = temp_set;
        cs     = 1'b0;
        for (int i = 0; i < rd_bits; i++) begin
            @(posedge sck);
            @(negedge sck);
            rd[15-i] = sio;
            if (i == 0)
                temp_set = ~t_save;
        end
        if (rd_bits < 16) begin
            mask = 16'hFFFF << (16 - rd_bits);
            check_val("rd_part", rd & mask, exp & mask);
            cs = 1'b1;
            #1;
            check_val("abort_z", {15'd0, sio}, 16'h0001);
            @(posedge sck);
            @(negedge sck);
            temp_set = t_save;
            return;
        end
        check_val("rd", rd, exp);
        @(posedge sck);
        @(negedge sck);
        check_val("wr_z", {15'd0, sio}, 16'h0001);
        for (int i = 15; i >= 0; i--) begin
            host_en  = 1'b1;
            host_val = wr[i];
            if (rst_wr && i == 8) begin
                rstn = 1'b0;
                @(posedge sck);
                @(negedge sck);
                rstn    = 1'b1;
                cs      = 1'b1;
                host_en = 1'b0;
                #1;
                check_val("rst_z", {15'd0, sio}, 16'h0001);
                break;
            end
            @(posedge sck);
            @(negedge sck);
        end
        host_en = 1'b0;
        if (!rst_wr) begin
            @(posedge sck);
            @(negedge sck);
            check_val("done_z", {15'd0, sio}, 16'h0001);
        end
        cs = 1'b1;
        @(posedge sck);
        @(negedge sck);
        temp_set = t_save;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstn     = 1'b0;
        cs       = 1'b0;
        host_en  = 1'b0;
        host_val = 1'b0;
        temp_set = temp_word(24);
        @(negedge sck);
        repeat (2) begin
            @(posedge sck);
            @(negedge sck);
            check_val("rst_z", {15'd0, sio}, 16'h0001);
        end
        rstn = 1'b1;
        cs   = 1'b1;
        repeat (2) begin
            @(posedge sck);
            @(negedge sck);
            check_val("idle_z", {15'd0, sio}, 16'h0001);
        end

        check_val("temp_word_pos", temp_word(24), 16'h0C00);
        check_val("temp_word_neg", temp_word(-25), 16'hF380);

        exp_q.push_back(16'h0C1F); run_frame(16'h0000, 16, 1'b0);
        temp_set = temp_word(-25);
        exp_q.push_back(16'hF39F); run_frame(16'h0012, 16, 1'b0);
        temp_set = 16'h0C00;
        exp_q.push_back(16'h0C1F); run_frame(16'h00FF, 16, 1'b0);
        exp_q.push_back(16'h8100); run_frame(16'h0012, 16, 1'b0);
        exp_q.push_back(16'h8100); run_frame(16'h0000, 8, 1'b0);
        exp_q.push_back(16'h8100); run_frame(16'h0000, 16, 1'b0);
        exp_q.push_back(16'h0C1F); run_frame(16'h0000, 8, 1'b0);
        temp_set = 16'hF380;
        exp_q.push_back(16'hF39F); run_frame(16'hAAFF, 16, 1'b0);
        exp_q.push_back(16'h8100); run_frame(16'h00FF, 16, 1'b1);
        exp_q.push_back(16'hF39F); run_frame(16'h0000, 16, 1'b0);

        check_val("sb_empty", 16'(exp_q.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
